// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider: FSM state encoding,
// counter-width helper and the divide-by-zero quotient fill bit.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        SUB,
        FIX,
        DONE
    } div_state_t;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1 values.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring step: trial-subtract the divisor from the partial remainder,
// keep the difference when it is non-negative, otherwise restore.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   a_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff    = a_i - {1'b0, d_i};
        q_bit_o = ~diff[WIDTH];
        a_o     = q_bit_o ? diff : a_i;
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per SHIFT/SUB pair.
// Define DIV_SIGNED_EN for two's-complement operation (adds the FIX state).
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Load_Dvd,
    input  logic             Load_Dvs,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             Done,
    output logic             DivZero
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   step_a;
    logic             step_bit;

`ifdef DIV_SIGNED_EN
    logic dvd_neg_q, dvd_neg_d;
    logic dvs_neg_q, dvs_neg_d;

    // Operand registers keep the raw loaded values so a reused divisor keeps its sign.
    assign dvd_mag = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
    assign dvs_mag = d_q[WIDTH-1]   ? -d_q   : d_q;
`else
    assign dvd_mag = dvd_q;
    assign dvs_mag = d_q;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i     (a_q),
        .d_i     (dvs_mag),
        .a_o     (step_a),
        .q_bit_o (step_bit)
    );

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch can leave a signal unassigned and infer a latch.
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        dvd_d   = dvd_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
`endif

        case (state_q)
            IDLE: begin
                if (Load_Dvd) dvd_d = Din;
                if (Load_Dvs) d_d   = Din;
                if (Run) begin
                    dz_d    = 1'b0;
                    state_d = INIT;
                end
            end
            INIT: begin
                a_d   = '0;
                cnt_d = '0;
                dz_d  = 1'b0;
                q_d   = dvd_mag;
`ifdef DIV_SIGNED_EN
                dvd_neg_d = dvd_q[WIDTH-1];
                dvs_neg_d = d_q[WIDTH-1];
`endif
                if (d_q == '0) begin
                    dz_d    = 1'b1;
                    q_d     = {WIDTH{DIV_ZERO_QUOT_BIT}};
                    a_d     = {1'b0, dvd_q};
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d     = {q_q[WIDTH-2:0], 1'b0};
                state_d = SUB;
            end
            SUB: begin
                a_d    = step_a;
                q_d[0] = step_bit;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
`ifdef DIV_SIGNED_EN
            FIX: begin
                if (dvd_neg_q ^ dvs_neg_q) q_d = -q_q;
                if (dvd_neg_q)             a_d = {1'b0, -a_q[WIDTH-1:0]};
                state_d = DONE;
            end
`endif
            DONE: begin
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
`endif
        end
    end

    assign Quot    = q_q;
    assign Rem     = a_q[WIDTH-1:0];
    assign Done    = (state_q == DONE);
    assign DivZero = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_restoring_divider;

    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 2 * W + 3;
`else
    localparam int LAT = 2 * W + 2;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Run = 1'b0;
    logic         Load_Dvd = 1'b0;
    logic         Load_Dvs = 1'b0;
    logic [W-1:0] Din = '0;
    logic [W-1:0] Quot;
    logic [W-1:0] Rem;
    logic         Done;
    logic         DivZero;

    int n_tests = 0;
    int n_fail  = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Load_Dvd (Load_Dvd),
        .Load_Dvs (Load_Dvs),
        .Din      (Din),
        .Quot     (Quot),
        .Rem      (Rem),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation in the signed build.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        int sa, sb, iq, ir;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1; lat = 2;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            iq = sa / sb;
            ir = sa % sb;
            q = iq[W-1:0]; r = ir[W-1:0]; dz = 1'b0; lat = LAT;
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk); Din = a; Load_Dvd = 1'b1;
        @(negedge Clk); Load_Dvd = 1'b0; Din = b; Load_Dvs = 1'b1;
        @(negedge Clk); Load_Dvs = 1'b0; Din = 8'hC3;
    endtask

    // Raises Run (optionally loading a new dividend in the same cycle), waits for Done
    // and reports the edge at which Done is first sampled high (edge 0 samples Run).
    // poke_at >= 0 pulses both loads with Din=0x11 after that edge.
    task automatic run_op(input bit with_dvd, input logic [W-1:0] dvd, input int poke_at,
                          output int obs_edge, output logic [W-1:0] q,
                          output logic [W-1:0] r, output logic dz);
        @(negedge Clk);
        Run = 1'b1;
        if (with_dvd) begin Din = dvd; Load_Dvd = 1'b1; end
        @(posedge Clk);
        obs_edge = -1;
        for (int e = 0; e < 100; e++) begin
            @(negedge Clk);
            Load_Dvd = 1'b0; Load_Dvs = 1'b0;
            if (e == poke_at) begin Din = 8'h11; Load_Dvd = 1'b1; Load_Dvs = 1'b1; end
            if (Done) begin obs_edge = e + 1; break; end
            @(posedge Clk);
        end
        Load_Dvd = 1'b0; Load_Dvs = 1'b0;
        q = Quot; r = Rem; dz = DivZero;
    endtask

    task automatic do_case(input string tag, input bit with_dvd, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int poke_at);
        logic [W-1:0] eq, er, oq, orr;
        logic         edz, odz;
        int           elat, olat;
        model(a, b, eq, er, edz, elat);
        run_op(with_dvd, a, poke_at, olat, oq, orr, odz);
        check({tag, "_latency"}, 32'(olat), 32'(elat));
        check({tag, "_quot"}, 32'(oq), 32'(eq));
        check({tag, "_rem"}, 32'(orr), 32'(er));
        check({tag, "_divzero"}, 32'(odz), 32'(edz));
        repeat (2) @(negedge Clk);
        check({tag, "_done_held"}, 32'(Done), 32'd1);
        check({tag, "_quot_held"}, 32'(Quot), 32'(eq));
        Run = 1'b0;
        @(negedge Clk);
        check({tag, "_done_fall"}, 32'(Done), 32'd0);
        check({tag, "_rem_idle"}, 32'(Rem), 32'(er));
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        // Reset state
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk); Reset = 1'b0;
        check("rst_quot", 32'(Quot), 32'd0);
        check("rst_rem", 32'(Rem), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_divzero", 32'(DivZero), 32'd0);

        // 100 / 7 with explicit constants, then via the model
        load(8'd100, 8'd7);
        do_case("u100d7", 1'b0, 8'd100, 8'd7, -1);
        check("u100d7_quot_const", 32'(Quot), 32'd14);
        check("u100d7_rem_const", 32'(Rem), 32'd2);

        // Extremes and divisor reuse (dividend loaded in the Run cycle)
        load(8'd255, 8'd1);
        do_case("u255d1", 1'b0, 8'd255, 8'd1, -1);
        do_case("reuse_d1", 1'b1, 8'd77, 8'd1, -1);
        load(8'd3, 8'd200);
        do_case("u3d200", 1'b0, 8'd3, 8'd200, -1);
        do_case("reuse_d200", 1'b1, 8'd250, 8'd200, -1);

        // Divide by zero, then a nonzero divisor clears the flag
        load(8'h5A, 8'h00);
        do_case("dz", 1'b0, 8'h5A, 8'h00, -1);
        check("dz_quot_const", 32'(Quot), 32'hFF);
        load(8'h5A, 8'd9);
        do_case("dz_clear", 1'b0, 8'h5A, 8'd9, -1);

        // Reset nine edges into a run, then a clean rerun
        load(8'd100, 8'd7);
        @(negedge Clk); Run = 1'b1;
        repeat (9) @(posedge Clk);
        @(negedge Clk); Reset = 1'b1; Run = 1'b0;
        @(negedge Clk); Reset = 1'b0;
        check("midrst_quot", 32'(Quot), 32'd0);
        check("midrst_rem", 32'(Rem), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        @(negedge Clk);
        check("midrst_idle", 32'(Done), 32'd0);
        load(8'd100, 8'd7);
        do_case("after_rst", 1'b0, 8'd100, 8'd7, -1);

        // Loads during SUB are ignored
        do_case("load_in_sub", 1'b0, 8'd100, 8'd7, 2);

`ifdef DIV_SIGNED_EN
        load(8'h9C, 8'd7);
        do_case("s_m100d7", 1'b0, 8'h9C, 8'd7, -1);
        check("s_m100d7_quot_const", 32'(Quot), 32'hF2);
        check("s_m100d7_rem_const", 32'(Rem), 32'hFE);
        load(8'd100, 8'hF9);
        do_case("s_100dm7", 1'b0, 8'd100, 8'hF9, -1);
        check("s_100dm7_quot_const", 32'(Quot), 32'hF2);
        check("s_100dm7_rem_const", 32'(Rem), 32'h02);
        load(8'h80, 8'hFF);
        do_case("s_mindm1", 1'b0, 8'h80, 8'hFF, -1);
        check("s_mindm1_quot_const", 32'(Quot), 32'h80);
        check("s_mindm1_rem_const", 32'(Rem), 32'h00);
`endif

        // Random operands, with an occasional zero divisor
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            load(ra, rb);
            do_case($sformatf("rand%0d", i), 1'b0, ra, rb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
